stopwatch_lap: RTL
==================

Name: stopwatch_lap

Overview:
- Single-clock-domain successor to the team's 6-digit stopwatch (MM:SS.cc).
- Replaces the ripple-clocked counter chain with one prescaler and synchronous enables.
- Adds edge-detected start/stop, lap (split) freeze/release, clear-when-stopped, a configurable wrap/saturate policy and a configurable segment polarity.
- Drives six 7-segment digit outputs directly. Sits between the debounced push-button inputs and the board display.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; must be a multiple of 100 and at least 200.
- WRAP, 1, at 59:59.99: 1 = roll over to 00:00.00 and keep running, 0 = hold at 59:59.99 and stop.
- SEG_ACTIVE_LOW, 0, 1 = all segment outputs inverted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_stop  in  1  debounced, clk-synchronous button; a rising edge toggles run/stop
- lap  in  1  debounced, clk-synchronous button; a rising edge performs the lap/clear action
- running  out  1  1 while counting
- lap_active  out  1  1 while the display shows a frozen lap value
- overflow  out  1  sticky; set on wrap or saturation
- m10  out  7  tens of minutes
- m1  out  7  minutes
- s10  out  7  tens of seconds
- s1  out  7  seconds
- s01  out  7  tenths of a second
- s001  out  7  hundredths of a second

Behaviour:
- Reset (rst=1 at a clk edge):
  - running=0, lap_active=0, overflow=0.
  - All count digits, lap latch digits and the prescaler = 0.
  - Edge-detect history registers = 1, so a button held through reset produces no edge.
  - All displays show 0.
- Edge detect:
  - An edge is input=1 while the registered previous value=0.
  - The action takes effect on the clock edge after the rising input is sampled.
- Prescaler:
  - DIV = CLK_HZ/100. Counts 0..DIV-1 only while running=1.
  - tick = running && prescaler==DIV-1. On tick the prescaler returns to 0.
  - While stopped the prescaler holds its value, so the fraction is preserved on resume.
- Digit chain (BCD, synchronous, all updated on tick):
  - d0 0-9, d1 0-9, d2 0-9, d3 0-5, d4 0-9, d5 0-5.
  - Each digit increments when tick and all lower digits are at their max.
  - A digit at its max with that condition true goes to 0.
- Terminal count 59:59.99 on tick:
  - WRAP=1: all digits go to 0, overflow<=1, running stays 1.
  - WRAP=0: digits hold, overflow<=1, running<=0.
  - With WRAP=0 and overflow=1, a start_stop edge is ignored until clear or reset.
- start_stop edge: running <= ~running. No other effect.
- lap edge, evaluated with the pre-edge state:
  - running=1, lap_active=0: latch the six count digits into the lap registers, lap_active<=1. Counting continues.
  - lap_active=1 (running or stopped): lap_active<=0; the display returns to the live count.
  - running=0, lap_active=0: clear. Digits, prescaler and overflow go to 0.
- Simultaneous start_stop and lap edges in one cycle: start_stop is applied, lap is ignored.
- Display source: lap registers when lap_active=1, otherwise the live digits. Output is registered; display latency is 1 cycle after the digit change.
- Segment encoding:
  - Bit order {g,f,e,d,c,b,a}, bit0 = a, active-high.
  - Digits 0-9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex). Non-BCD values map to 00.
  - With SEG_ACTIVE_LOW=1, every output is the bitwise inverse.
- Reset mid-count or mid-lap follows the reset row above and takes priority over all edges in the same cycle.

Test Plan:
- CLK_HZ=1000 (DIV=10), WRAP=1: reset, pulse start_stop, run 1000 clocks -> s1=06 (1), s01=3F, s001=3F, running=1; stop, wait 500 clocks -> display unchanged; restart -> the next tick comes after the remaining prescaler count, not a full DIV.
- Running at 00:03.40: pulse lap -> display frozen at 00:03.40 and lap_active=1; 200 clocks later pulse lap -> display shows 00:03.60 and lap_active=0.
- Stopped at 00:05.00: pulse lap -> all digits show 3F (0), overflow=0; pulse start_stop with lap in the same cycle -> running=1, no clear, no lap.
- Force 59:59.99, WRAP=1: one tick -> 00:00.00, overflow=1, running=1. Repeat with WRAP=0 -> holds 59:59.99, running=0, and a following start_stop edge is ignored.
- start_stop held high through reset and released 5 cycles later -> running stays 0. Assert rst while running with lap_active=1 -> the next cycle shows all zeros, running=0, lap_active=0.
- SEG_ACTIVE_LOW=1 after reset -> all outputs 7'h40. Digit value 8 -> 7'h00.

Source files
------------

// File: rtl/stopwatch_lap.sv
// -----------------------------------------------------------------------------
// stopwatch_lap : MM:SS.cc stopwatch with lap freeze, clear and 7-seg drive.
//
// One prescaler turns the system clock into a 100 Hz tick (only while
// running); a BCD digit chain counts hundredths up to 59:59.99. Button
// inputs are already debounced and synchronous to clk; rising edges are
// detected here. Each digit output is a registered 7-segment pattern.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   start_stop   rising edge toggles run/stop
//   lap          rising edge: lap freeze / lap release / clear (when stopped)
//   running      1 while counting
//   lap_active   1 while the display shows a frozen lap value
//   overflow     sticky; set when 59:59.99 is passed (wrap or saturate)
//   m10..s001    segment patterns {g,f,e,d,c,b,a}, minutes tens .. hundredths
// -----------------------------------------------------------------------------
module stopwatch_lap #(
  parameter int CLK_HZ         = 50000000,
  parameter int WRAP           = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  output logic       running,
  output logic       lap_active,
  output logic       overflow,
  output logic [6:0] m10,
  output logic [6:0] m1,
  output logic [6:0] s10,
  output logic [6:0] s1,
  output logic [6:0] s01,
  output logic [6:0] s001
);

  localparam int              DIV      = CLK_HZ / 100;
  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(DIV - 1);
  localparam logic [41:0]     SEG_ZERO = {6{7'h3F}};
  localparam logic [41:0]     SEG_RST  = (SEG_ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;

  // Segment pattern for one BCD digit; anything outside 0-9 is blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Highest value of digit idx (0 = hundredths): tens-of-seconds and
  // tens-of-minutes stop at 5, all others at 9.
  function automatic logic [3:0] digit_max(input int idx);
    logic [3:0] mx;
    case (idx)
      3, 5:    mx = 4'd5;
      default: mx = 4'd9;
    endcase
    return mx;
  endfunction

  // State registers; digits packed as six BCD nibbles, hundredths in [3:0].
  logic          run_q, run_d;
  logic          lap_act_q, lap_act_d;
  logic          ovf_q, ovf_d;
  logic          ss_prev_q, lap_prev_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [23:0]   lap_q, lap_d;
  logic [41:0]   seg_q, seg_d;

  logic          ss_edge_s, lap_edge_s, tick_s, term_s;
  logic [6:0]    carry_s;
  logic [23:0]   cnt_inc_s;
  logic [23:0]   disp_src_s;
  logic [41:0]   seg_raw_s;

  assign ss_edge_s  = start_stop & ~ss_prev_q;
  assign lap_edge_s = lap & ~lap_prev_q;
  assign tick_s     = run_q & (pre_q == PRE_MAX);

  // BCD ripple-carry: a digit advances only when every lower digit is at max.
  always_comb begin
    carry_s    = 7'b0;
    cnt_inc_s  = cnt_q;
    carry_s[0] = tick_s;
    for (int i = 0; i < 6; i++) begin
      if (carry_s[i]) begin
        if (cnt_q[i*4 +: 4] == digit_max(i)) begin
          cnt_inc_s[i*4 +: 4] = 4'd0;
          carry_s[i+1]        = 1'b1;
        end else begin
          cnt_inc_s[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
          carry_s[i+1]        = 1'b0;
        end
      end else begin
        cnt_inc_s[i*4 +: 4] = cnt_q[i*4 +: 4];
        carry_s[i+1]        = 1'b0;
      end
    end
    term_s = carry_s[6];
  end

  // Next-state: prescaler, count, terminal policy, then button actions.
  // A start_stop edge wins over a lap edge in the same cycle.
  always_comb begin
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    lap_d     = lap_q;
    run_d     = run_q;
    lap_act_d = lap_act_q;
    ovf_d     = ovf_q;

    if (run_q) begin
      if (tick_s) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end

    if (term_s) begin
      ovf_d = 1'b1;
      if (WRAP != 0) begin
        cnt_d = cnt_inc_s;
      end else begin
        // Saturate: keep 59:59.99 on the display and stop.
        cnt_d = cnt_q;
        run_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc_s;
    end

    if (ss_edge_s) begin
      // After saturation the only way out is clear or reset.
      if ((WRAP == 0) && ovf_q) begin
        run_d = run_d;
      end else begin
        run_d = ~run_q;
      end
    end else if (lap_edge_s) begin
      if (lap_act_q) begin
        lap_act_d = 1'b0;
      end else if (run_q) begin
        lap_d     = cnt_q;
        lap_act_d = 1'b1;
      end else begin
        cnt_d = 24'h000000;
        pre_d = '0;
        ovf_d = 1'b0;
      end
    end else begin
      lap_act_d = lap_act_q;
    end
  end

  // Display source and segment encoding, registered below.
  always_comb begin
    disp_src_s = lap_act_q ? lap_q : cnt_q;
    seg_raw_s  = {seg_encode(disp_src_s[23:20]), seg_encode(disp_src_s[19:16]),
                  seg_encode(disp_src_s[15:12]), seg_encode(disp_src_s[11:8]),
                  seg_encode(disp_src_s[7:4]),   seg_encode(disp_src_s[3:0])};
    if (SEG_ACTIVE_LOW != 0) begin
      seg_d = ~seg_raw_s;
    end else begin
      seg_d = seg_raw_s;
    end
  end

  // State update; button history resets to 1 so a held button gives no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      lap_act_q  <= 1'b0;
      ovf_q      <= 1'b0;
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      pre_q      <= '0;
      cnt_q      <= 24'h000000;
      lap_q      <= 24'h000000;
      seg_q      <= SEG_RST;
    end else begin
      run_q      <= run_d;
      lap_act_q  <= lap_act_d;
      ovf_q      <= ovf_d;
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      lap_q      <= lap_d;
      seg_q      <= seg_d;
    end
  end

  assign running    = run_q;
  assign lap_active = lap_act_q;
  assign overflow   = ovf_q;
  assign m10        = seg_q[41:35];
  assign m1         = seg_q[34:28];
  assign s10        = seg_q[27:21];
  assign s1         = seg_q[20:14];
  assign s01        = seg_q[13:7];
  assign s001       = seg_q[6:0];

endmodule
